dec_scan_ctrl: RTL
==================

// Module: dec_scan_ctrl
// PURPOSE
//   Scan sequencer that sits directly upstream of the 3-to-8 decoder stage.
//   Generates the 3-bit select and the enable that drive the decoder's in/en inputs.
//   Steps through digit/row slots 0..num_dig at a divided rate, with optional dead-time blanking.
//   Used for time-multiplexed display or row scanning; the decoder turns sel/en into one-hot strobes.
// PARAMETERS
//   TICK_DIV   1000  clk cycles per slot; legal range >= 2
//   BLANK_CYC  8     cycles per slot with en forced low (SCAN_BLANK_EN only); legal range 1..TICK_DIV-1
//   CNT_W      $clog2(TICK_DIV)  slot counter width; derived, do not override
// PORTS
//   clk        in   1  single clock; all logic on posedge clk
//   rst        in   1  synchronous, active-high reset
//   run        in   1  level; 1 = scan, 0 = stop and idle
//   num_dig    in   3  index of last active slot (0..7 -> 1..8 slots)
//   sel        out  3  slot index; drives decoder in[2:0]
//   en         out  1  slot enable; drives decoder en
//   frame_done out  1  one-cycle pulse on frame wrap
//   busy       out  1  high whenever state != IDLE
// BEHAVIOUR
//   - Clock/reset: one clock (clk); synchronous active-high reset (rst), sampled on posedge clk.
//   - All outputs registered. Input-to-output latency is 1 clk.
//   - Reset: state=IDLE, sel=0, en=0, frame_done=0, busy=0, slot cnt=0, num_dig_q=0.
//     rst dominates run and every other input.
//   - States: IDLE, BLANK, DRIVE.
//   - IDLE: sel=0, en=0.
//     run=1 -> cnt=0, num_dig_q<=num_dig, busy=1.
//     Next state is BLANK with SCAN_BLANK_EN, DRIVE without it.
//   - cnt increments every cycle in BLANK/DRIVE and wraps at TICK_DIV-1.
//   - BLANK: en=0. At cnt==BLANK_CYC-1 -> DRIVE.
//   - DRIVE: en=1. At cnt==TICK_DIV-1 (slot end):
//       sel!=num_dig_q -> sel<=sel+1.
//       sel==num_dig_q -> sel<=0, frame_done=1 for that one cycle, num_dig_q<=num_dig.
//       Then -> BLANK (with macro) or stay in DRIVE with cnt=0 (without macro).
//   - en is never 1 while sel changes: the sel update and the en drop occur on the same edge in blank mode.
//   - num_dig is latched only at frame start. A change mid-frame takes effect after the next wrap.
//   - num_dig=0: sel stays 0, and frame_done pulses at every slot end.
//   - run=0 in BLANK/DRIVE: next edge -> IDLE, sel=0, en=0, busy=0, cnt=0.
//     No frame_done is issued and the partial frame is discarded.
//   - run=1 again: restart at sel=0, cnt=0. No resume.
//   - Frame period = (num_dig_q+1)*TICK_DIV cycles.
//   - Slot period is TICK_DIV regardless of the macro.
// CONFIGURATION
//   SCAN_BLANK_EN defined:
//     Each slot begins with BLANK_CYC cycles of en=0, then TICK_DIV-BLANK_CYC cycles of en=1.
//     Suppresses ghosting on slot change.
//   SCAN_BLANK_EN undefined:
//     The BLANK state and its compare logic are not built, and BLANK_CYC is ignored.
//     en=1 for every cycle of every slot while busy; sel changes with en=1.
// TESTING  (TICK_DIV=10, BLANK_CYC=2, decoder instantiated downstream; check its out is one-hot or 0)
//   1 Reset: rst=1 for 3 clk with run=1, num_dig=7 -> sel=0, en=0, frame_done=0, busy=0 throughout.
//     First active slot starts on the edge after rst=0.
//   2 Full scan, num_dig=7, run=1:
//     sel steps 0..7; per slot en=0 for 2 clk, then en=1 for 8 clk.
//     frame_done is one clk high every 80 clk, on the 7->0 wrap.
//   3 num_dig=2: sel follows 0,1,2,0 with a 30-clk frame.
//     Set num_dig=5 while sel=1 -> frame completes at 2, then the next frame runs 0..5.
//   4 num_dig=0: sel is constantly 0 and frame_done pulses every 10 clk.
//     Decoder out=8'b0000_0001 during en=1.
//   5 run=0 at sel=3, cnt=5 -> next clk en=0, sel=0, busy=0, no frame_done.
//     run=1 three clk later -> restart at sel=0 in BLANK.
//   6 SCAN_BLANK_EN undefined, num_dig=7:
//     en=1 on every cycle from the edge after run=1; 10-clk slots, 80-clk frame_done period.

Source files
------------

// File: rtl/dec_scan_ctrl.sv
// dec_scan_ctrl -- scan sequencer feeding a 3-to-8 decoder stage.
//
// Steps a 3-bit slot index (sel) through slots 0..num_dig. Each slot lasts
// TICK_DIV clocks. The enable (en) drives the decoder's en input, and
// frame_done pulses for one cycle when the frame wraps back to slot 0.
//
// Build option: define SCAN_BLANK_EN to blank en for the first BLANK_CYC
// cycles of every slot. This suppresses ghosting on slot change. Without the
// macro, the BLANK state is not built and BLANK_CYC has no effect on the logic.
//
// Parameters
//   TICK_DIV   clk cycles per slot (>= 2)
//   BLANK_CYC  blanked cycles per slot (1..TICK_DIV-1), SCAN_BLANK_EN only
//   CNT_W      slot counter width, derived from TICK_DIV
//
// Ports
//   clk        in   clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   run        in   1 = scan, 0 = return to idle
//   num_dig    in   index of the last active slot (latched at frame start)
//   sel        out  slot index -> decoder in[2:0]
//   en         out  slot enable -> decoder en
//   frame_done out  one-cycle pulse on frame wrap
//   busy       out  high whenever not idle
module dec_scan_ctrl #(
  parameter int TICK_DIV  = 1000,
  parameter int BLANK_CYC = 8,
  parameter int CNT_W     = $clog2(TICK_DIV)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [2:0] num_dig,
  output logic [2:0] sel,
  output logic       en,
  output logic       frame_done,
  output logic       busy
);

  if (TICK_DIV < 2 || BLANK_CYC < 1 || BLANK_CYC > TICK_DIV - 1) begin : g_bad_params
    $error("dec_scan_ctrl: TICK_DIV must be >= 2 and BLANK_CYC in 1..TICK_DIV-1");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

`ifdef SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, DRIVE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd2} state_t;
`endif

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       sel_n;
  logic [2:0]       num_dig_q, num_dig_q_n;
  logic             frame_done_n;
  logic             en_n;
  logic             busy_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sel        <= '0;
      num_dig_q  <= '0;
      frame_done <= 1'b0;
      en         <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sel        <= sel_n;
      num_dig_q  <= num_dig_q_n;
      frame_done <= frame_done_n;
      en         <= en_n;
      busy       <= busy_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    sel_n        = sel;
    num_dig_q_n  = num_dig_q;
    frame_done_n = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        sel_n = '0;
        if (run) begin
          num_dig_q_n = num_dig;
`ifdef SCAN_BLANK_EN
          state_n     = BLANK;
`else
          state_n     = DRIVE;
`endif
        end
      end
`ifdef SCAN_BLANK_EN
      BLANK: begin
        // The counter keeps running through the blank window, so the slot
        // length stays TICK_DIV whether or not blanking is built in.
        cnt_n = cnt + 1'b1;
        if (cnt == BLANK_LAST) state_n = DRIVE;
      end
`endif
      DRIVE: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (sel == num_dig_q) begin
            sel_n        = '0;
            frame_done_n = 1'b1;
            num_dig_q_n  = num_dig;
          end else begin
            sel_n = sel + 3'd1;
          end
`ifdef SCAN_BLANK_EN
          state_n = BLANK;
`endif
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Dropping run discards the partial frame without a frame_done.
    if (state != IDLE && !run) begin
      state_n      = IDLE;
      cnt_n        = '0;
      sel_n        = '0;
      frame_done_n = 1'b0;
    end

    // en and busy are registered from the next state, so en falls on the
    // same edge that updates sel when blanking is enabled.
    en_n   = (state_n == DRIVE);
    busy_n = (state_n != IDLE);
  end

endmodule
